// File: rtl/rgba_gray_pixel_core_if.sv
// Line-stream bundle between the c0 read-response stage and the grayscale core.
// The master side drives the input line and receives the converted line.
interface rgba_gray_pixel_core_if;
  logic [511:0] data_in;
  logic         valid_in;
  logic [511:0] data_out;
  logic         valid_out;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out
  );
endinterface

// File: rtl/rgba_gray_pixel_core.sv
// RGBA8888 -> grayscale converter for one 512b line (16 pixels) per cycle.
// It uses programmable luma coefficients, a fixed-latency pipeline and per-run line/saturation stats.
module rgba_gray_pixel_core #(
  parameter int unsigned LATENCY = 1,
  parameter logic [7:0]  DEF_CR  = 8'd77,
  parameter logic [7:0]  DEF_CG  = 8'd150,
  parameter logic [7:0]  DEF_CB  = 8'd29
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_wr_en,
  input  logic [24:0]           cfg_wr_data,
  input  logic                  stats_clr,
  rgba_gray_pixel_core_if.slave px,
  output logic [24:0]           cfg_active,
  output logic                  cfg_pending,
  output logic [31:0]           line_cnt,
  output logic [31:0]           sat_cnt
);
  localparam logic [24:0] CFG_DEFAULT = {1'b0, DEF_CB, DEF_CG, DEF_CR};

  logic [24:0]        cfg_active_reg;
  logic [24:0]        cfg_pend_data_reg;
  logic               cfg_pending_reg;
  logic [31:0]        line_cnt_reg;
  logic [31:0]        sat_cnt_reg;

  logic [511:0]       conv_data;
  logic [15:0]        sat_flags;
  logic [4:0]         sat_count;

  logic [511:0]       pipe_data_reg [LATENCY];
  logic [4:0]         pipe_sat_reg  [LATENCY];
  logic [LATENCY-1:0] pipe_valid_reg;
  logic               apply_ok;

  // Stage-0 compute reads cfg_active_reg directly, so each line sees one snapshot.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_pixel
      logic [7:0]  r;
      logic [7:0]  g;
      logic [7:0]  b;
      logic [7:0]  a;
      logic [17:0] sum;
      logic [10:0] y;
      logic [7:0]  luma;

      assign r    = px.data_in[32*gi +: 8];
      assign g    = px.data_in[32*gi + 8 +: 8];
      assign b    = px.data_in[32*gi + 16 +: 8];
      assign a    = px.data_in[32*gi + 24 +: 8];
      assign sum  = 18'(cfg_active_reg[7:0])   * 18'(r)
                  + 18'(cfg_active_reg[15:8])  * 18'(g)
                  + 18'(cfg_active_reg[23:16]) * 18'(b);
      assign y    = 11'((sum + 18'd128) >> 8);
      assign sat_flags[gi] = (y > 11'd255);
      assign luma = sat_flags[gi] ? 8'hFF : y[7:0];
      assign conv_data[32*gi +: 32] = {(cfg_active_reg[24] ? 8'hFF : a), luma, luma, luma};
    end
  endgenerate

  always_comb begin
    sat_count = '0;
    for (int i = 0; i < 16; i++) begin
      sat_count = sat_count + 5'(sat_flags[i]);
    end
  end

  // Data registers only load on a valid beat, so the last stage holds its value while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid_reg <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data_reg[i] <= '0;
        pipe_sat_reg[i]  <= '0;
      end
    end else begin
      pipe_valid_reg[0] <= px.valid_in;
      if (px.valid_in) begin
        pipe_data_reg[0] <= conv_data;
        pipe_sat_reg[0]  <= sat_count;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        if (pipe_valid_reg[i-1]) begin
          pipe_data_reg[i] <= pipe_data_reg[i-1];
          pipe_sat_reg[i]  <= pipe_sat_reg[i-1];
        end
      end
    end
  end

  assign apply_ok = !px.valid_in && (pipe_valid_reg == '0);

  // A write in the same cycle as the apply window wins; it gets applied on a later idle edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_active_reg    <= CFG_DEFAULT;
      cfg_pend_data_reg <= CFG_DEFAULT;
      cfg_pending_reg   <= 1'b0;
    end else if (cfg_wr_en) begin
      cfg_pend_data_reg <= cfg_wr_data;
      cfg_pending_reg   <= 1'b1;
    end else if (cfg_pending_reg && apply_ok) begin
      cfg_active_reg    <= cfg_pend_data_reg;
      cfg_pending_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      line_cnt_reg <= '0;
      sat_cnt_reg  <= '0;
    end else if (pipe_valid_reg[LATENCY-1]) begin
      line_cnt_reg <= line_cnt_reg + 32'd1;
      sat_cnt_reg  <= sat_cnt_reg + 32'(pipe_sat_reg[LATENCY-1]);
    end
  end

  assign px.data_out  = pipe_data_reg[LATENCY-1];
  assign px.valid_out = pipe_valid_reg[LATENCY-1];
  assign cfg_active   = cfg_active_reg;
  assign cfg_pending  = cfg_pending_reg;
  assign line_cnt     = line_cnt_reg;
  assign sat_cnt      = sat_cnt_reg;
endmodule

// File: tb/tb_rgba_gray_pixel_core.sv
// Directed bench for rgba_gray_pixel_core: a LATENCY=1 instance and a LATENCY=3 instance share stimulus.
`timescale 1ns/1ps
module tb_rgba_gray_pixel_core;
  localparam logic [24:0] CFG_DEF = {1'b0, 8'd29, 8'd150, 8'd77};
  localparam logic [24:0] CFG_SAT = {1'b1, 8'hFF, 8'hFF, 8'hFF};
  localparam logic [24:0] CFG_NEW = {1'b0, 8'd0, 8'd0, 8'd128};

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_wr_en;
  logic [24:0]  cfg_wr_data;
  logic         stats_clr;
  logic [511:0] din;
  logic         vin;

  logic [24:0]  cfg_active1, cfg_active3;
  logic         cfg_pending1, cfg_pending3;
  logic [31:0]  line_cnt1, sat_cnt1, line_cnt3, sat_cnt3;

  int tests = 0;
  int fails = 0;

  rgba_gray_pixel_core_if bus1();
  rgba_gray_pixel_core_if bus3();

  assign bus1.data_in  = din;
  assign bus1.valid_in = vin;
  assign bus3.data_in  = din;
  assign bus3.valid_in = vin;

  always #5 clk = ~clk;

  rgba_gray_pixel_core #(.LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_data(cfg_wr_data),
    .stats_clr(stats_clr), .px(bus1), .cfg_active(cfg_active1), .cfg_pending(cfg_pending1),
    .line_cnt(line_cnt1), .sat_cnt(sat_cnt1)
  );

  rgba_gray_pixel_core #(.LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_data(cfg_wr_data),
    .stats_clr(stats_clr), .px(bus3), .cfg_active(cfg_active3), .cfg_pending(cfg_pending3),
    .line_cnt(line_cnt3), .sat_cnt(sat_cnt3)
  );

  // Pixel i takes p0..p3 according to i%4.
  function automatic logic [511:0] fill4(input logic [31:0] p0, input logic [31:0] p1,
                                         input logic [31:0] p2, input logic [31:0] p3);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0:       l[32*i +: 32] = p0;
        1:       l[32*i +: 32] = p1;
        2:       l[32*i +: 32] = p2;
        default: l[32*i +: 32] = p3;
      endcase
    end
    return l;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (bus1.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus1.valid_out); end
    tests++; if (bus1.data_out !== '0) begin fails++; $display("FAIL reset_data: got %h expected 0", bus1.data_out); end
    tests++; if (cfg_active1 !== CFG_DEF) begin fails++; $display("FAIL reset_cfg: got %h expected %h", cfg_active1, CFG_DEF); end
    tests++; if (cfg_pending1 !== 1'b0 || line_cnt1 !== 32'd0 || sat_cnt1 !== 32'd0) begin
      fails++; $display("FAIL reset_stats: got pend=%b lines=%0d sat=%0d expected 0/0/0", cfg_pending1, line_cnt1, sat_cnt1);
    end
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    logic [511:0] exp;
    exp = fill4(32'h12808080, 32'h12808080, 32'h12808080, 32'h12808080);
    @(negedge clk); din = exp; vin = 1'b1;
    @(negedge clk); vin = 1'b0;
    tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp) begin
      fails++; $display("FAIL default_line: got v=%b %h expected v=1 %h", bus1.valid_out, bus1.data_out, exp);
    end
    tests++; if (bus3.valid_out !== 1'b0) begin fails++; $display("FAIL lat3_early: got %b expected 0", bus3.valid_out); end
    @(negedge clk);
    tests++; if (bus1.valid_out !== 1'b0 || bus1.data_out !== exp) begin
      fails++; $display("FAIL data_hold: got v=%b %h expected v=0 %h", bus1.valid_out, bus1.data_out, exp);
    end
    tests++; if (line_cnt1 !== 32'd1 || sat_cnt1 !== 32'd0) begin
      fails++; $display("FAIL default_stats: got lines=%0d sat=%0d expected 1/0", line_cnt1, sat_cnt1);
    end
    tests++; if (bus3.valid_out !== 1'b0) begin fails++; $display("FAIL lat3_early2: got %b expected 0", bus3.valid_out); end
    @(negedge clk);
    tests++; if (bus3.valid_out !== 1'b1 || bus3.data_out !== exp) begin
      fails++; $display("FAIL lat3_line: got v=%b %h expected v=1 %h", bus3.valid_out, bus3.data_out, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_coefficients();
    logic [511:0] in1, in2, exp1, exp2;
    in1  = fill4(32'h000000FF, 32'h0000FF00, 32'h00FF0000, 32'hFFFFFFFF);
    exp1 = fill4(32'h004D4D4D, 32'h00959595, 32'h001D1D1D, 32'hFFFFFFFF);
    in2  = fill4(32'h5A1E140A, 32'h5A1E140A, 32'h5A1E140A, 32'h5A1E140A);
    exp2 = fill4(32'h5A121212, 32'h5A121212, 32'h5A121212, 32'h5A121212);
    @(negedge clk); din = in1; vin = 1'b1;
    @(negedge clk); din = in2;
    tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp1) begin
      fails++; $display("FAIL coeff_rgbw: got v=%b %h expected v=1 %h", bus1.valid_out, bus1.data_out, exp1);
    end
    @(negedge clk); vin = 1'b0;
    tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp2) begin
      fails++; $display("FAIL coeff_mixed: got v=%b %h expected v=1 %h", bus1.valid_out, bus1.data_out, exp2);
    end
    @(negedge clk);
    tests++; if (line_cnt1 !== 32'd3 || sat_cnt1 !== 32'd0) begin
      fails++; $display("FAIL coeff_stats: got lines=%0d sat=%0d expected 3/0", line_cnt1, sat_cnt1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [511:0] exp;
    exp = fill4(32'hFFFFFFFF, 32'hFF030303, 32'hFFFEFEFE, 32'hFFFFFFFF);
    cfg_wr_data = CFG_SAT; cfg_wr_en = 1'b1;
    @(negedge clk); cfg_wr_en = 1'b0;
    tests++; if (cfg_pending1 !== 1'b1 || cfg_active1 !== CFG_DEF) begin
      fails++; $display("FAIL sat_cfg_latch: got pend=%b act=%h expected 1 %h", cfg_pending1, cfg_active1, CFG_DEF);
    end
    @(negedge clk);
    tests++; if (cfg_pending1 !== 1'b0 || cfg_active1 !== CFG_SAT) begin
      fails++; $display("FAIL sat_cfg_apply: got pend=%b act=%h expected 0 %h", cfg_pending1, cfg_active1, CFG_SAT);
    end
    din = fill4(32'h00FFFFFF, 32'h00010101, 32'h00555555, 32'h00565656); vin = 1'b1;
    @(negedge clk); vin = 1'b0;
    tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp) begin
      fails++; $display("FAIL sat_line: got v=%b %h expected v=1 %h", bus1.valid_out, bus1.data_out, exp);
    end
    @(negedge clk);
    tests++; if (line_cnt1 !== 32'd4 || sat_cnt1 !== 32'd8) begin
      fails++; $display("FAIL sat_stats: got lines=%0d sat=%0d expected 4/8", line_cnt1, sat_cnt1);
    end
    cfg_wr_data = CFG_DEF; cfg_wr_en = 1'b1;
    @(negedge clk); cfg_wr_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back_cfg();
    logic [511:0] line, exp_old, exp_new;
    line    = fill4(32'h12808080, 32'h12808080, 32'h12808080, 32'h12808080);
    exp_old = line;
    exp_new = fill4(32'h12404040, 32'h12404040, 32'h12404040, 32'h12404040);
    cfg_wr_data = CFG_NEW;
    for (int b = 0; b < 100; b++) begin
      @(negedge clk);
      if (b > 0) begin
        tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp_old) begin
          fails++; $display("FAIL traffic_line%0d: got v=%b %h expected v=1 %h", b - 1, bus1.valid_out, bus1.data_out, exp_old);
        end
      end
      if (b == 60) begin
        tests++; if (cfg_pending1 !== 1'b1 || cfg_active1 !== CFG_DEF) begin
          fails++; $display("FAIL traffic_pending: got pend=%b act=%h expected 1 %h", cfg_pending1, cfg_active1, CFG_DEF);
        end
      end
      din = line; vin = 1'b1; cfg_wr_en = (b == 50);
    end
    @(negedge clk); vin = 1'b0; cfg_wr_en = 1'b0;
    tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp_old) begin
      fails++; $display("FAIL traffic_line99: got v=%b %h expected v=1 %h", bus1.valid_out, bus1.data_out, exp_old);
    end
    @(negedge clk);
    tests++; if (bus1.valid_out !== 1'b0 || cfg_pending1 !== 1'b1 || cfg_active1 !== CFG_DEF) begin
      fails++; $display("FAIL drain_pending: got v=%b pend=%b act=%h expected 0 1 %h", bus1.valid_out, cfg_pending1, cfg_active1, CFG_DEF);
    end
    tests++; if (line_cnt1 !== 32'd104) begin fails++; $display("FAIL traffic_count: got %0d expected 104", line_cnt1); end
    @(negedge clk);
    tests++; if (cfg_pending1 !== 1'b0 || cfg_active1 !== CFG_NEW) begin
      fails++; $display("FAIL drain_apply: got pend=%b act=%h expected 0 %h", cfg_pending1, cfg_active1, CFG_NEW);
    end
    din = line; vin = 1'b1;
    @(negedge clk); vin = 1'b0;
    tests++; if (bus1.valid_out !== 1'b1 || bus1.data_out !== exp_new) begin
      fails++; $display("FAIL new_cfg_line: got v=%b %h expected v=1 %h", bus1.valid_out, bus1.data_out, exp_new);
    end
    cfg_wr_data = CFG_DEF; cfg_wr_en = 1'b1;
    @(negedge clk); cfg_wr_en = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (cfg_active1 !== CFG_DEF) begin fails++; $display("FAIL cfg_restore: got %h expected %h", cfg_active1, CFG_DEF); end
  endtask

  task automatic test_stats_clr();
    din = fill4(32'h12808080, 32'h12808080, 32'h12808080, 32'h12808080); vin = 1'b1;
    @(negedge clk); vin = 1'b0;
    tests++; if (bus1.valid_out !== 1'b1 || sat_cnt1 !== 32'd8) begin
      fails++; $display("FAIL clr_precond: got v=%b sat=%0d expected 1/8", bus1.valid_out, sat_cnt1);
    end
    stats_clr = 1'b1;
    @(negedge clk); stats_clr = 1'b0;
    tests++; if (line_cnt1 !== 32'd0 || sat_cnt1 !== 32'd0) begin
      fails++; $display("FAIL clr_on_retire: got lines=%0d sat=%0d expected 0/0", line_cnt1, sat_cnt1);
    end
    vin = 1'b1;
    @(negedge clk); vin = 1'b0;
    @(negedge clk);
    tests++; if (line_cnt1 !== 32'd1) begin fails++; $display("FAIL clr_recount: got %0d expected 1", line_cnt1); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      din = fill4(32'h12808080, 32'h000000FF, 32'h12808080, 32'h000000FF); vin = 1'b1;
      cfg_wr_data = CFG_SAT; cfg_wr_en = (b == 0);
    end
    @(negedge clk); vin = 1'b0; cfg_wr_en = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    tests++; if (bus3.valid_out !== 1'b0 || bus3.data_out !== '0) begin
      fails++; $display("FAIL midreset_out: got v=%b %h expected v=0 0", bus3.valid_out, bus3.data_out);
    end
    tests++; if (cfg_active3 !== CFG_DEF || cfg_pending3 !== 1'b0) begin
      fails++; $display("FAIL midreset_cfg: got act=%h pend=%b expected %h 0", cfg_active3, cfg_pending3, CFG_DEF);
    end
    tests++; if (line_cnt3 !== 32'd0 || sat_cnt3 !== 32'd0) begin
      fails++; $display("FAIL midreset_stats: got lines=%0d sat=%0d expected 0/0", line_cnt3, sat_cnt3);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (bus3.valid_out !== 1'b0 || bus1.valid_out !== 1'b0) begin
        fails++; $display("FAIL midreset_quiet%0d: got v3=%b v1=%b expected 0 0", c, bus3.valid_out, bus1.valid_out);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_wr_en = 1'b0; cfg_wr_data = '0; stats_clr = 1'b0; din = '0; vin = 1'b0;
    test_reset();
    test_defaults();
    test_coefficients();
    test_saturation();
    test_back_to_back_cfg();
    test_stats_clr();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
